// File: rtl/hilo_mdu_seq_if.sv
// Bus between the decode/regfile stage and the HI/LO multiply/divide sequencer.
// The master issues operations and mt/mf requests; the slave owns HI/LO.
interface hilo_mdu_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  mt_hi;
  logic                  mt_lo;
  logic [DATA_WIDTH-1:0] mt_wd;
  logic                  mf_req;
  logic                  busy;
  logic                  done;
  logic                  dz;
  logic                  stall;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;

  modport master (
    output start, op, A, B, mt_hi, mt_lo, mt_wd, mf_req,
    input  busy, done, dz, stall, HI, LO
  );

  modport slave (
    input  start, op, A, B, mt_hi, mt_lo, mt_wd, mf_req,
    output busy, done, dz, stall, HI, LO
  );
endinterface

// File: rtl/hilo_mdu_seq.sv
// Iterative multiply/divide engine owning HI/LO: shift-add multiply and
// restoring divide, one bit per clock, with sign fix-up in a final FIX cycle.
module hilo_mdu_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RST,
  hilo_mdu_seq_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;       // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]    opd;       // multiplicand or divisor magnitude
  logic [W-1:0]    a_orig;
  logic            is_div;
  logic            sgn_q;
  logic            sgn_r;
  logic            div_zero;
  logic            busy;
  logic            done;
  logic            dz;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;

  logic [W-1:0]    mul_add;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_trial;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  fix_prod;
  logic [W-1:0]    fix_hi;
  logic [W-1:0]    fix_lo;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? -v : v;
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    mul_add   = '0;
    mul_sum   = '0;
    mul_next  = '0;
    div_trial = '0;
    div_next  = '0;
    fix_prod  = '0;
    fix_hi    = '0;
    fix_lo    = '0;

    mul_add  = acc[0] ? opd : '0;
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc[W-1:1]};

    // Negative trial result means the divisor did not fit: keep the shifted remainder.
    div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, opd};
    div_next  = div_trial[W] ? {acc[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc[W-2:0], 1'b1};

    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_hi = sgn_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        fix_lo = sgn_q ? -acc[W-1:0]   : acc[W-1:0];
      end
    end else begin
      fix_prod = sgn_q ? -acc : acc;
      fix_hi   = fix_prod[2*W-1:W];
      fix_lo   = fix_prod[W-1:0];
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      sgn_q    <= 1'b0;
      sgn_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dz       <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            sgn_q    <= bus.op[0] & (bus.A[W-1] ^ bus.B[W-1]);
            sgn_r    <= bus.op[0] & bus.A[W-1];
            a_orig   <= bus.A;
            div_zero <= (bus.B == '0);
            if (bus.op[1]) begin
              opd <= mag(bus.B, bus.op[0]);
              acc <= {{W{1'b0}}, mag(bus.A, bus.op[0])};
            end else begin
              opd <= mag(bus.A, bus.op[0]);
              acc <= {{W{1'b0}}, mag(bus.B, bus.op[0])};
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (bus.mt_hi) hi_q <= bus.mt_wd;
            if (bus.mt_lo) lo_q <= bus.mt_wd;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          hi_q  <= fix_hi;
          lo_q  <= fix_lo;
          if (is_div) dz <= div_zero;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Same-cycle hold for the PC: anything touching HI/LO or the engine waits.
  assign bus.stall = busy & (bus.start | bus.mf_req | bus.mt_hi | bus.mt_lo);
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.dz    = dz;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
endmodule

// File: tb/tb_hilo_mdu_seq.sv
// Directed bench for hilo_mdu_seq: arithmetic results, latency, dz flag,
// hazard stalls, mt writes and mid-operation reset.
module tb_hilo_mdu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;
  int   t_start = 0;
  int   done_seen;

  hilo_mdu_seq_if #(.DATA_WIDTH(32)) bus ();

  hilo_mdu_seq #(.DATA_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    t_start   = cyc_cnt;
  endtask

  // Returns in the done cycle; checks 33-cycle latency and the done pulse.
  task automatic wait_done(input string tag);
    int guard = 0;
    while (bus.busy && guard < 100) begin
      tick(1);
      guard++;
    end
    check({tag, "_latency"}, 64'(cyc_cnt - t_start), 64'd33);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start_op(op, a, b);
    wait_done(tag);
    check({tag, "_hi"}, 64'(bus.HI), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.LO), 64'(exp_lo));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.A      = '0;
    bus.B      = '0;
    bus.mt_hi  = 1'b0;
    bus.mt_lo  = 1'b0;
    bus.mt_wd  = '0;
    bus.mf_req = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    check("rst_busy",  64'(bus.busy),  64'd0);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_dz",    64'(bus.dz),    64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_hi",    64'(bus.HI),    64'd0);
    check("rst_lo",    64'(bus.LO),    64'd0);

    // multu max * max, with busy length and single-cycle done
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_e0", 64'(bus.busy), 64'd1);
    wait_done("multu");
    check("multu_hi", 64'(bus.HI), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.LO), 64'h0000_0001);
    check("multu_busy_fell", 64'(bus.busy), 64'd0);
    tick(1);
    check("multu_done_1cyc", 64'(bus.done), 64'd0);

    run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu",      2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    check("divu_dz", 64'(bus.dz), 64'd0);

    // divide by zero, dz kept across a multiply, cleared by a good divide
    run_op("divu_by0",  2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    check("divu_by0_dz", 64'(bus.dz), 64'd1);
    run_op("multu_keep_dz", 2'b00, 32'd4, 32'd5, 32'd0, 32'd20);
    check("multu_keep_dz_dz", 64'(bus.dz), 64'd1);
    run_op("divu_clr",  2'b10, 32'd9, 32'd3, 32'd0, 32'd3);
    check("divu_clr_dz", 64'(bus.dz), 64'd0);

    // hazards during mult 5*6; HI/LO currently 0 / 3
    start_op(2'b01, 32'd5, 32'd6);
    tick(3);
    bus.mf_req = 1'b1;
    #1;
    check("hz_mf_stall", 64'(bus.stall), 64'd1);
    bus.mf_req = 1'b0;
    bus.mt_hi  = 1'b1;
    bus.mt_wd  = 32'hDEAD;
    #1;
    check("hz_mt_stall", 64'(bus.stall), 64'd1);
    tick(1);
    check("hz_mt_ignored_hi", 64'(bus.HI), 64'd0);
    bus.mt_hi  = 1'b0;
    bus.op     = 2'b10;
    bus.A      = 32'd1;
    bus.B      = 32'd1;
    bus.start  = 1'b1;
    #1;
    check("hz_start_stall", 64'(bus.stall), 64'd1);
    tick(1);
    bus.start  = 1'b0;
    tick(5);
    check("hz_mid_hi", 64'(bus.HI), 64'd0);
    check("hz_mid_lo", 64'(bus.LO), 64'd3);
    wait_done("hz_mult");
    check("hz_mult_hi", 64'(bus.HI), 64'd0);
    check("hz_mult_lo", 64'(bus.LO), 64'd30);
    bus.mf_req = 1'b1;
    #1;
    check("hz_mf_done_nostall", 64'(bus.stall), 64'd0);
    bus.mf_req = 1'b0;
    bus.mt_hi  = 1'b1;
    bus.mt_wd  = 32'hDEAD;
    tick(1);
    bus.mt_hi  = 1'b0;
    check("hz_mthi_hi", 64'(bus.HI), 64'hDEAD);
    check("hz_mthi_lo", 64'(bus.LO), 64'd30);
    check("hz_no_restart_busy", 64'(bus.busy), 64'd0);

    // mtlo alone, then both strobes together
    bus.mt_lo = 1'b1;
    bus.mt_wd = 32'h55AA;
    tick(1);
    check("mtlo_lo", 64'(bus.LO), 64'h55AA);
    check("mtlo_hi", 64'(bus.HI), 64'hDEAD);
    bus.mt_hi = 1'b1;
    bus.mt_wd = 32'h1234;
    tick(1);
    bus.mt_hi = 1'b0;
    bus.mt_lo = 1'b0;
    check("mtboth_hi", 64'(bus.HI), 64'h1234);
    check("mtboth_lo", 64'(bus.LO), 64'h1234);

    // reset 10 cycles into a divide, with dz set beforehand
    run_op("divu_by0_b", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    start_op(2'b10, 32'd100, 32'd7);
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_hi",   64'(bus.HI),   64'd0);
    check("midrst_lo",   64'(bus.LO),   64'd0);
    check("midrst_dz",   64'(bus.dz),   64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      tick(1);
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    run_op("post_rst_multu", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_mdu_seq.md
# hilo_mdu_seq

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It replaces the single-cycle combinational `mult`/`div` path with one shared iterative engine: shift-add for multiply, restoring division for divide, one bit per clock. It sits beside the register file and is fed from RD1/RD2. It asserts a stall to the PC/fetch logic whenever an instruction needs HI/LO or the engine while an operation is in flight.

## Interface

- `DATA_WIDTH`, 32, operand width; the iteration count equals `DATA_WIDTH`.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled on the rising edge.
- `op`  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- `A`  in  DATA_WIDTH  rs operand (multiplicand / dividend).
- `B`  in  DATA_WIDTH  rt operand (multiplier / divisor).
- `mt_hi`, `mt_lo`  in  1 each  mthi / mtlo write strobes.
- `mt_wd`  in  DATA_WIDTH  mthi/mtlo write data.
- `mf_req`  in  1  current instruction is mfhi/mflo.
- `busy`  out  1  engine running.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.
- `dz`  out  1  sticky divide-by-zero flag for the last completed divide.
- `stall`  out  1  hold PC and suppress the current instruction's writeback.
- `HI`, `LO`  out  DATA_WIDTH each  architectural HI/LO.

## Operation

- **States:** IDLE, RUN, FIX.
- **IDLE → RUN** on `start`.
  - Latch `op`.
  - Latch |A| and |B| for signed ops, raw values for unsigned ops.
  - Record result sign: product / quotient sign = A[msb]^B[msb]; remainder sign = A[msb].
  - Clear the iteration counter.
- **RUN:** one iteration per cycle, `DATA_WIDTH` cycles total.
  - Multiply: conditional add of the multiplicand into the upper half of a 2·DATA_WIDTH accumulator, then shift right.
  - Divide: shift the remainder/quotient pair left, trial-subtract the divisor, restore on negative, set the quotient bit otherwise.
  - The counter reaching `DATA_WIDTH-1` moves the FSM to FIX.
- **FIX → IDLE.**
  - Apply two's-complement sign correction.
  - Write HI/LO: multiply gives HI = product[63:32], LO = product[31:0]; divide gives HI = remainder, LO = quotient.
  - Pulse `done`.
- **Divide by zero:**
  - Still runs the full latency.
  - Result is forced to HI = A (original), LO = all-ones.
  - `dz` = 1.
  - Any completed divide with B≠0 clears `dz`; multiplies leave `dz` unchanged.
- **Signed overflow:** 0x80000000 div −1 gives LO = 0x80000000, HI = 0 (natural wrap, no flag).
- **mthi/mtlo:**
  - In IDLE, writes HI or LO at the edge.
  - If `mt_hi` and `mt_lo` are both asserted, both registers take `mt_wd`.
  - While busy, the write is ignored and `stall` is raised until idle, after which the instruction retires.
- **start in IDLE together with mt_*:** `start` wins and the mt write is ignored (the decoder never issues both).
- **start while busy:** ignored, no restart. `stall` is raised so the issuing instruction is held and re-presented.
- **stall** = busy & (start | mf_req | mt_hi | mt_lo). Combinational.
- **Reset (including mid-operation):**
  - FSM goes to IDLE; counter and accumulators are cleared.
  - HI = LO = 0; busy = done = dz = stall = 0.
  - The in-flight result is discarded.

## Timing

- `start` is accepted at edge E0; `busy` is high from after E0.
- Iterations run on edges E1..E32 (for DATA_WIDTH = 32).
- FIX occurs at E33: HI/LO update and `busy` falls after E33.
- `done` is high for exactly the cycle following E33.
- Result latency is 33 cycles from acceptance. A back-to-back `start` is accepted in the `done` cycle.
- `mf_req` in the `done` cycle does not stall and sees the new HI/LO.
- `stall` has no registered delay. The PC logic must treat it as a same-cycle hold.
- HI/LO change only at FIX edges, mt edges, or reset; never mid-iteration.

## Test plan

- **multu:** A = B = 0xFFFFFFFF → after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001; `done` high one cycle; `busy` high 33 cycles.
- **mult:** A = −3 (0xFFFFFFFD), B = 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- **div and divu:**
  - div A = −7, B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - divu 100 / 7 → LO = 14, HI = 2; `dz` = 0.
- **divu 100 / 0:** → HI = 100, LO = 0xFFFFFFFF, `dz` = 1; a following divu 9 / 3 → `dz` = 0, LO = 3, HI = 0.
- **Hazards:** during mult 5·6, assert `mf_req`, `mt_hi` (wd = 0xDEAD), and a second `start`.
  - Each raises `stall`.
  - HI/LO remain unchanged until FIX, then read 0 / 30.
  - mthi is applied only once idle, giving HI = 0xDEAD.
- **Reset mid-run:** assert `RST` 10 cycles into a divide → next cycle busy = 0, HI = LO = 0, `dz` = 0, no `done` pulse. A new multu 2·3 then completes normally with LO = 6.
